// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch path and
// the load/store path. One request is latched at a time, a fixed-latency access
// is sequenced, then read data is returned with a one-cycle done pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (contested grants alternate ports);
// when undefined, data always beats fetch.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 0 = fetch, 1 = data
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              win;                // port chosen if a grant happens now

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;

  // Contested requests go to the port not granted last time.
  always_comb begin
    if (i_req && d_req) win = ~last_q;
    else                win = d_req;
  end
`else
  // Fixed priority: data beats fetch.
  always_comb begin
    win = d_req;
  end
`endif

  // Next-state logic: grant in IDLE, count down in ACCESS, pulse in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = win;
          addr_d  = win ? d_addr : i_addr;
          we_d    = win & d_we;
          wdata_d = win ? d_wdata : '0;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // Stores leave the owner's read data untouched.
          if (!we_q) begin
            if (owner_q) d_rdata_d = m_rdata;
            else         i_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-granted port, reset to fetch so the first contested grant goes to data.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`endif

  // Outputs decode from state so reset clears them without a clock edge.
  // The write strobe is limited to the first ACCESS cycle by the counter value.
  assign m_en    = (state_q == ACCESS);
  assign m_we    = m_en && we_q && (cnt_q == CNT_LOAD);
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_done  = (state_q == DONE) && !owner_q;
  assign d_done  = (state_q == DONE) && owner_q;
  assign busy    = (state_q != IDLE);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
